// File: rtl/mem_xfer_fsm.sv
// Memory-transfer control FSM for the multicycle datapath.
// Sequences STORE/LOAD through MAR/MDR with an MFC wait and timeout abort.
module mem_xfer_fsm #(
  parameter int NREG    = 4,
  parameter int SEL_W   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             MFC,
  input  logic [SEL_W-1:0] p1,
  input  logic [SEL_W-1:0] p2,
  output logic             PCinc,
  output logic             MARin,
  output logic             MDRwrite,
  output logic             MDRout,
  output logic             memEn,
  output logic             memOp,
  output logic [NREG-1:0]  ri_out,
  output logic [NREG-1:0]  rj_out,
  output logic [NREG-1:0]  ri_in,
  output logic             busy,
  output logic             finish,
  output logic             err
);

  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT =
    (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_SETUP,
    S_MEM,
    S_LDR,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic             op_q;
  logic [SEL_W-1:0] p1_q;
  logic [SEL_W-1:0] p2_q;
  logic             tmo_hit;

  // Codes outside 1..NREG-1 select the top (default) register.
  function automatic logic [NREG-1:0] dec(
    input logic [SEL_W-1:0] c
  );
    logic [NREG-1:0] v;
    logic            hit;
    v   = '0;
    hit = 1'b0;
    for (int i = 0; i < NREG - 1; i++) begin
      if (32'(c) == i + 1) begin
        v[i] = 1'b1;
        hit  = 1'b1;
      end
    end
    if (!hit) v[NREG-1] = 1'b1;
    return v;
  endfunction

  assign tmo_hit = (TIMEOUT != 0) && (cnt == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= 1'b0;
      p1_q  <= '0;
      p2_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        op_q <= op;
        p1_q <= p1;
        p2_q <= p2;
        cnt  <= '0;
      end else if (state == S_MEM && !MFC && !tmo_hit) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = S_IDLE;
    unique case (state)
      S_IDLE:  state_nx = start ? S_ADDR : S_IDLE;
      S_ADDR:  state_nx = op_q ? S_SETUP : S_DATA;
      S_DATA:  state_nx = S_SETUP;
      S_SETUP: state_nx = S_MEM;
      S_MEM: begin
        if (MFC)          state_nx = op_q ? S_LDR : S_DONE;
        else if (tmo_hit) state_nx = S_ERR;
        else              state_nx = S_MEM;
      end
      S_LDR:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    PCinc    = 1'b0;
    MARin    = 1'b0;
    MDRwrite = 1'b0;
    MDRout   = 1'b0;
    memEn    = 1'b0;
    memOp    = 1'b0;
    ri_out   = '0;
    rj_out   = '0;
    ri_in    = '0;
    busy     = (state != S_IDLE);
    finish   = 1'b0;
    err      = 1'b0;
    unique case (state)
      S_ADDR: begin
        PCinc  = 1'b1;
        MARin  = 1'b1;
        rj_out = dec(p2_q);
      end
      S_DATA: begin
        MDRwrite = 1'b1;
        ri_out   = dec(p1_q);
      end
      S_MEM: begin
        memEn = 1'b1;
        memOp = op_q;
      end
      S_LDR: begin
        MDRout = 1'b1;
        ri_in  = dec(p1_q);
      end
      S_DONE:  finish = 1'b1;
      S_ERR:   err    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_xfer_fsm.sv
// Bench for mem_xfer_fsm: per-transfer expected traces checked every cycle
// on three configurations (NREG=4/T=15, NREG=8/T=15, NREG=4/T=0).
module tb_mem_xfer_fsm;

  typedef struct packed {
    logic       pcinc;
    logic       marin;
    logic       mdrwrite;
    logic       mdrout;
    logic       memen;
    logic       memop;
    logic [7:0] ri_out;
    logic [7:0] rj_out;
    logic [7:0] ri_in;
    logic       busy;
    logic       finish;
    logic       err;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] start_v = '0;
  logic       op = 1'b0;
  logic       mfc = 1'b0;
  logic [5:0] p1 = '0;
  logic [5:0] p2 = '0;

  int    vectors = 0;
  int    miscompares = 0;
  int    sel = 0;
  bit    exp_on = 1'b0;
  outs_t exp_o = '0;
  outs_t trace[$];
  outs_t got[3];

  always #5 clk = ~clk;

  logic       pc0, ma0, mw0, mo0, me0, mp0, bz0, fi0, er0;
  logic [3:0] ro0, rj0, rn0;
  logic       pc1, ma1, mw1, mo1, me1, mp1, bz1, fi1, er1;
  logic [7:0] ro1, rj1, rn1;
  logic       pc2, ma2, mw2, mo2, me2, mp2, bz2, fi2, er2;
  logic [3:0] ro2, rj2, rn2;

  mem_xfer_fsm #(.NREG(4), .SEL_W(6), .TIMEOUT(15)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .op(op), .MFC(mfc),
    .p1(p1), .p2(p2), .PCinc(pc0), .MARin(ma0), .MDRwrite(mw0),
    .MDRout(mo0), .memEn(me0), .memOp(mp0), .ri_out(ro0),
    .rj_out(rj0), .ri_in(rn0), .busy(bz0), .finish(fi0), .err(er0)
  );

  mem_xfer_fsm #(.NREG(8), .SEL_W(6), .TIMEOUT(15)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .op(op), .MFC(mfc),
    .p1(p1), .p2(p2), .PCinc(pc1), .MARin(ma1), .MDRwrite(mw1),
    .MDRout(mo1), .memEn(me1), .memOp(mp1), .ri_out(ro1),
    .rj_out(rj1), .ri_in(rn1), .busy(bz1), .finish(fi1), .err(er1)
  );

  mem_xfer_fsm #(.NREG(4), .SEL_W(6), .TIMEOUT(0)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .op(op), .MFC(mfc),
    .p1(p1), .p2(p2), .PCinc(pc2), .MARin(ma2), .MDRwrite(mw2),
    .MDRout(mo2), .memEn(me2), .memOp(mp2), .ri_out(ro2),
    .rj_out(rj2), .ri_in(rn2), .busy(bz2), .finish(fi2), .err(er2)
  );

  assign got[0] = {pc0, ma0, mw0, mo0, me0, mp0, {4'b0, ro0},
                   {4'b0, rj0}, {4'b0, rn0}, bz0, fi0, er0};
  assign got[1] = {pc1, ma1, mw1, mo1, me1, mp1, ro1, rj1, rn1,
                   bz1, fi1, er1};
  assign got[2] = {pc2, ma2, mw2, mo2, me2, mp2, {4'b0, ro2},
                   {4'b0, rj2}, {4'b0, rn2}, bz2, fi2, er2};

  task automatic cmp(input string nm, input outs_t g, input outs_t e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, g, e);
    end
  endtask

  task automatic pin(input string nm, input int g, input int e);
    vectors++;
    if (g != e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, g, e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) cmp("cycle", got[sel], exp_o);
  end

  function automatic logic [7:0] onehot(input int c, input int nreg);
    logic [7:0] one;
    int         idx;
    one = 8'd1;
    idx = (c >= 1 && c < nreg) ? c - 1 : nreg - 1;
    return one << idx;
  endfunction

  // Expected output per cycle of one transfer, from the start-sample edge on.
  function automatic void build(input bit ld, input int p1v, input int p2v,
                                input int k, input int nreg, input int tmo);
    outs_t r;
    bit    ok;
    int    m;
    ok = (k != 0) && (tmo == 0 || k <= tmo);
    m  = ok ? k : tmo;
    trace.delete();
    r = '0; r.busy = 1; r.pcinc = 1; r.marin = 1;
    r.rj_out = onehot(p2v, nreg);
    trace.push_back(r);
    if (!ld) begin
      r = '0; r.busy = 1; r.mdrwrite = 1;
      r.ri_out = onehot(p1v, nreg);
      trace.push_back(r);
    end
    r = '0; r.busy = 1;
    trace.push_back(r);
    for (int i = 0; i < m; i++) begin
      r = '0; r.busy = 1; r.memen = 1; r.memop = ld;
      trace.push_back(r);
    end
    if (ok) begin
      if (ld) begin
        r = '0; r.busy = 1; r.mdrout = 1;
        r.ri_in = onehot(p1v, nreg);
        trace.push_back(r);
      end
      r = '0; r.busy = 1; r.finish = 1;
      trace.push_back(r);
    end else begin
      r = '0; r.busy = 1; r.err = 1;
      trace.push_back(r);
    end
    r = '0;
    trace.push_back(r);
    trace.push_back(r);
  endfunction

  function automatic int count(input int f);
    int n;
    n = 0;
    foreach (trace[i]) begin
      case (f)
        0: n += int'(trace[i].memen);
        1: n += int'(trace[i].err);
        2: n += int'(trace[i].finish);
        default: n += int'(trace[i].mdrwrite);
      endcase
    end
    return n;
  endfunction

  function automatic int first_finish();
    foreach (trace[i]) if (trace[i].finish) return i + 1;
    return -1;
  endfunction

  task automatic run(input int s, input bit ld, input int p1v,
                     input int p2v, input int k, input bit pert);
    int nreg;
    int tmo;
    int fm;
    nreg = (s == 1) ? 8 : 4;
    tmo  = (s == 2) ? 0 : 15;
    fm   = ld ? 3 : 4;
    build(ld, p1v, p2v, k, nreg, tmo);
    @(posedge clk); #1;
    sel = s; op = ld; p1 = 6'(p1v); p2 = 6'(p2v); mfc = 1'b0;
    start_v = '0; start_v[s] = 1'b1;
    exp_o = '0; exp_on = 1'b1;
    for (int j = 0; j < trace.size(); j++) begin
      @(posedge clk); #1;
      start_v = '0;
      mfc = (k != 0) && (j + 1 >= fm + k - 1);
      if (pert && trace[j].busy) begin
        start_v[s] = 1'($urandom);
        op = 1'($urandom);
        p1 = 6'($urandom);
        p2 = 6'($urandom);
        if (j + 1 < fm) mfc = 1'($urandom);
      end
      exp_o = trace[j];
    end
    @(posedge clk); #1;
    exp_on = 1'b0; mfc = 1'b0; start_v = '0;
  endtask

  initial begin
    #12;
    cmp("reset_u0", got[0], '0);
    cmp("reset_u1", got[1], '0);
    cmp("reset_u2", got[2], '0);
    @(posedge clk); #1 reset = 1'b0;

    build(1'b0, 2, 3, 1, 4, 15);
    pin("model_store_rj", int'(trace[0].rj_out), 4);
    pin("model_store_ri", int'(trace[1].ri_out), 2);
    pin("model_store_fin", first_finish(), 5);
    run(0, 1'b0, 2, 3, 1, 1'b0);

    build(1'b1, 1, 0, 3, 4, 15);
    pin("model_load_rj", int'(trace[0].rj_out), 8);
    pin("model_load_riin", int'(trace[5].ri_in), 1);
    pin("model_load_memen", count(0), 3);
    pin("model_load_mdrw", count(3), 0);
    run(0, 1'b1, 1, 0, 3, 1'b0);

    build(1'b0, 2, 3, 0, 4, 15);
    pin("model_tmo_memen", count(0), 15);
    pin("model_tmo_err", count(1), 1);
    pin("model_tmo_fin", count(2), 0);
    run(0, 1'b0, 2, 3, 0, 1'b0);

    build(1'b1, 3, 1, 15, 4, 15);
    pin("model_edge_err", count(1), 0);
    run(0, 1'b1, 3, 1, 15, 1'b0);
    run(0, 1'b0, 1, 2, 16, 1'b0);

    build(1'b0, 9, 0, 1, 8, 15);
    pin("model_n8_default", int'(trace[1].ri_out), 128);
    run(1, 1'b0, 7, 5, 1, 1'b0);
    run(1, 1'b0, 9, 0, 2, 1'b0);
    run(1, 1'b1, 4, 63, 1, 1'b0);

    run(0, 1'b1, 2, 3, 2, 1'b1);
    run(0, 1'b0, 3, 2, 4, 1'b1);

    build(1'b0, 3, 1, 101, 4, 0);
    pin("model_t0_memen", count(0), 101);
    run(2, 1'b0, 3, 1, 101, 1'b0);

    @(posedge clk); #1;
    sel = 0; op = 1'b0; p1 = 6'd2; p2 = 6'd3; mfc = 1'b0;
    start_v = 3'b001;
    @(posedge clk); #1 start_v = '0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1 cmp("reset_async", got[0], '0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cmp("post_reset", got[0], '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
